// File: rtl/fwht_sequency_reorder_if.sv
// AXI-Stream style bundle used on both sides of the sequency reorder buffer.
// The input side leaves tlast/tuser unused; the output side drives them.
interface fwht_sequency_reorder_if #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned UW    = 12
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [UW-1:0]    tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/fwht_sequency_reorder.sv
// Ping-pong frame buffer: captures 2^L_WIDTH coefficients in natural
// (Hadamard) order and replays them in sequency (Walsh) order with the
// sequency index on tuser and tlast on the final beat of each frame.
module fwht_sequency_reorder #(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned L_WIDTH = 12
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  fwht_sequency_reorder_if.slave   s_axis,
  fwht_sequency_reorder_if.master  m_axis
);

  localparam int unsigned N = 1 << L_WIDTH;
  localparam logic [L_WIDTH-1:0] CNT_MAX = '1;

  logic                 run;
  logic [1:0]           full;
  logic [1:0]           full_nx;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [L_WIDTH-1:0]   wr_cnt;
  logic [L_WIDTH-1:0]   rd_cnt;
  logic [WIDTH-1:0]     mem [2*N];

  logic                 wr_fire;
  logic                 wr_done;
  logic                 rd_issue;
  logic                 rd_done;
  logic [L_WIDTH-1:0]   gray;
  logic [L_WIDTH-1:0]   rd_addr;
  logic [2:0]           fill;

  // Read pipeline stage (memory output register)
  logic                 rd_vld;
  logic                 rd_last;
  logic [L_WIDTH-1:0]   rd_user;
  logic [WIDTH-1:0]     rd_data;

  // Two-entry output skid: head is presented, tail is overflow
  logic [1:0]           occ;
  logic                 pop;
  logic [WIDTH-1:0]     head_data;
  logic [WIDTH-1:0]     tail_data;
  logic [L_WIDTH-1:0]   head_user;
  logic [L_WIDTH-1:0]   tail_user;
  logic                 head_last;
  logic                 tail_last;

  logic                 unused_sideband;
  assign unused_sideband = ^{s_axis.tlast, s_axis.tuser};

  assign s_axis.tready = run & ~full[wr_bank];
  assign wr_fire       = s_axis.tvalid & s_axis.tready;
  assign wr_done       = wr_fire & (wr_cnt == CNT_MAX);

  // Room is judged on occupancy after this cycle's pop so a steady
  // ready-high sink sees one beat per cycle without bubbles.
  assign pop      = (occ != 2'd0) & m_axis.tready;
  assign fill     = 3'(occ) + 3'(rd_vld) - 3'(pop);
  assign rd_issue = full[rd_bank] & (fill < 3'd2);
  assign rd_done  = rd_issue & (rd_cnt == CNT_MAX);

  assign m_axis.tvalid = (occ != 2'd0);
  assign m_axis.tdata  = head_data;
  assign m_axis.tuser  = head_user;
  assign m_axis.tlast  = head_last;

  // Sequency index to natural address: bit-reversed Gray code
  always_comb begin
    gray    = rd_cnt ^ (rd_cnt >> 1);
    rd_addr = '0;
    for (int unsigned i = 0; i < L_WIDTH; i++) begin
      rd_addr[i] = gray[L_WIDTH-1-i];
    end
  end

  // Bank flag update: a set on one bank and a clear on the other may coincide
  always_comb begin
    full_nx = full;
    if (wr_done) full_nx[wr_bank] = 1'b1;
    if (rd_done) full_nx[rd_bank] = 1'b0;
  end

  // Frame memory: write port and registered read port, contents not reset
  always_ff @(posedge ACLK) begin
    if (wr_fire)  mem[{wr_bank, wr_cnt}] <= s_axis.tdata;
    if (rd_issue) rd_data <= mem[{rd_bank, rd_addr}];
  end

  // Bank pointers, counters, flags and read-stage sideband
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run     <= 1'b0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      rd_user <= '0;
      rd_last <= 1'b0;
    end else begin
      run  <= 1'b1;
      full <= full_nx;
      if (wr_fire) wr_cnt  <= wr_cnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (rd_issue) begin
        rd_cnt  <= rd_cnt + 1'b1;
        rd_user <= rd_cnt;
        rd_last <= (rd_cnt == CNT_MAX);
      end
      if (rd_done) rd_bank <= ~rd_bank;
      rd_vld <= rd_issue;
    end
  end

  // Output skid: push from read stage, pop on handshake, head always presented
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_user <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_user <= '0;
      tail_last <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (rd_vld) begin
            head_data <= rd_data;
            head_user <= rd_user;
            head_last <= rd_last;
            occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (rd_vld && pop) begin
            head_data <= rd_data;
            head_user <= rd_user;
            head_last <= rd_last;
          end else if (rd_vld) begin
            tail_data <= rd_data;
            tail_user <= rd_user;
            tail_last <= rd_last;
            occ       <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_data <= tail_data;
            head_user <= tail_user;
            head_last <= tail_last;
            if (rd_vld) begin
              tail_data <= rd_data;
              tail_user <= rd_user;
              tail_last <= rd_last;
            end else begin
              occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwht_sequency_reorder.sv
// Scoreboard bench for the sequency reorder buffer (WIDTH=16, N=8).
module tb_fwht_sequency_reorder;

  localparam int W = 16;
  localparam int L = 3;
  localparam int N = 8;

  typedef struct {
    logic [W-1:0] d;
    logic [L-1:0] u;
    logic         l;
  } exp_t;

  logic ACLK;
  logic ARESETN;

  fwht_sequency_reorder_if #(.WIDTH(W), .UW(L)) s_if ();
  fwht_sequency_reorder_if #(.WIDTH(W), .UW(L)) m_if ();

  fwht_sequency_reorder #(.WIDTH(W), .L_WIDTH(L)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  // Hand-derived sequency -> natural address order for N=8
  int unsigned seq_tab [8] = '{0, 4, 6, 2, 3, 7, 5, 1};

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pop_count = 0;
  int   first_pop = 0;
  int   last_pop = 0;
  int   stall_cycles = 0;
  bit   rand_gaps = 0;
  int   sink_mode = 0;
  exp_t sb [$];

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Random sink ready when enabled
  initial forever begin
    @(posedge ACLK);
    #1;
    if (sink_mode == 1) m_if.tready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops scoreboard on each output handshake, checks hold on stall
  initial begin
    bit           prev_stall;
    logic [W-1:0] pd;
    logic [L-1:0] pu;
    logic         pl;
    exp_t         e;
    prev_stall = 0;
    pd = '0;
    pu = '0;
    pl = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata},
                {1'b1, pl, pu, pd});
        end
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", {m_if.tuser, m_if.tdata}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("out_data", m_if.tdata, e.d);
            check("out_user", m_if.tuser, e.u);
            check("out_last", m_if.tlast, e.l);
          end
          if (pop_count == 0) first_pop = cyc;
          last_pop = cyc;
          pop_count++;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        pd = m_if.tdata;
        pu = m_if.tuser;
        pl = m_if.tlast;
      end
    end
  end

  // Drive one beat; caller is aligned just after a rising edge
  task automatic send_beat(input logic [W-1:0] d, output bit ok);
    int g;
    ok = 0;
    if (rand_gaps) begin
      s_if.tvalid = 1'b0;
      g = $urandom_range(0, 1);
      repeat (g) begin
        @(posedge ACLK);
        #1;
      end
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    for (int c = 0; c < 400; c++) begin
      @(negedge ACLK);
      if (s_if.tready) begin
        @(posedge ACLK);
        #1;
        ok = 1;
        break;
      end
      stall_cycles++;
    end
    s_if.tvalid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [W-1:0] d [8], output bit ok);
    exp_t e;
    bit   b;
    ok = 1;
    for (int i = 0; i < N; i++) begin
      send_beat(d[i], b);
      if (!b) begin
        ok = 0;
        return;
      end
    end
    for (int w = 0; w < N; w++) begin
      e.d = d[seq_tab[w]];
      e.u = 3'(w);
      e.l = (w == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic ramp(input int base, output logic [W-1:0] d [8]);
    for (int i = 0; i < N; i++) d[i] = 16'(base + i);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge ACLK);
      if (sb.size() == 0 && !m_if.tvalid) begin
        done = 1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [W-1:0] fr [8];
    bit ok;

    ARESETN     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b0;

    // 1. Reset release
    repeat (5) begin
      @(negedge ACLK);
      check("reset_outputs", {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, 32'd0);
    end
    ARESETN = 1'b1;
    #1;
    check("tready_before_edge", 32'(s_if.tready), 32'd0);
    @(negedge ACLK);
    check("tready_after_release", 32'(s_if.tready), 32'd1);

    // 2. Single frame with latency
    @(posedge ACLK);
    #1;
    m_if.tready = 1'b1;
    pop_count = 0;
    ramp(0, fr);
    send_frame(fr, ok);
    @(negedge ACLK);
    check("latency_t1", 32'(m_if.tvalid), 32'd0);
    @(negedge ACLK);
    check("latency_t2", 32'(m_if.tvalid), 32'd0);
    @(negedge ACLK);
    check("latency_first_valid", 32'(m_if.tvalid), 32'd1);
    @(posedge ACLK);
    #1;
    wait_drain("drain_single");
    check("single_count", 32'(pop_count), 32'd8);

    // 3. Back-to-back frames
    pop_count = 0;
    stall_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      ramp(8 * k, fr);
      send_frame(fr, ok);
    end
    wait_drain("drain_b2b");
    check("b2b_input_stalls", 32'(stall_cycles), 32'd0);
    check("b2b_count", 32'(pop_count), 32'd24);
    check("b2b_no_gap", 32'(last_pop - first_pop), 32'd23);

    // 4. Backpressure and overflow
    m_if.tready = 1'b0;
    pop_count = 0;
    stall_cycles = 0;
    ramp(0, fr);
    send_frame(fr, ok);
    ramp(8, fr);
    send_frame(fr, ok);
    check("bp_first16_no_stall", 32'(stall_cycles), 32'd0);
    repeat (4) @(negedge ACLK);
    check("bp_tready_low", 32'(s_if.tready), 32'd0);
    check("bp_head", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, {1'b1, 1'b0, 3'd0, 16'd0});
    @(posedge ACLK);
    #1;
    fork
      begin
        ramp(16, fr);
        send_frame(fr, ok);
      end
      begin
        repeat (6) @(posedge ACLK);
        #1;
        m_if.tready = 1'b1;
      end
    join
    check("bp_input_resumed", 32'(ok), 32'd1);
    wait_drain("drain_bp");
    check("bp_count", 32'(pop_count), 32'd24);

    // 5. Random valid/ready
    pop_count = 0;
    rand_gaps = 1;
    sink_mode = 1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
      send_frame(fr, ok);
    end
    rand_gaps = 0;
    sink_mode = 0;
    m_if.tready = 1'b1;
    wait_drain("drain_random");
    check("random_count", 32'(pop_count), 32'd160);

    // 6. Mid-operation reset
    m_if.tready = 1'b0;
    pop_count = 0;
    ramp(16'h40, fr);
    send_frame(fr, ok);
    for (int i = 0; i < 5; i++) send_beat(16'(16'h80 + i), ok);
    m_if.tready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    m_if.tready = 1'b0;
    check("pre_reset_pops", 32'(pop_count), 32'd3);
    #1;
    ARESETN = 1'b0;
    #1;
    check("reset_drops_valid", {s_if.tready, m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, 32'd0);
    sb.delete();
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("tready_after_mid_reset", 32'(s_if.tready), 32'd1);
    @(posedge ACLK);
    #1;
    m_if.tready = 1'b1;
    pop_count = 0;
    ramp(0, fr);
    send_frame(fr, ok);
    wait_drain("drain_after_reset");
    repeat (5) @(posedge ACLK);
    check("after_reset_count", 32'(pop_count), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
